// File: rtl/lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_initiator
// Brief    : MEM-stage load/store initiator. Issues one aligned beat or splits
//            misaligned accesses into byte beats; extends load data, aborts a
//            stalled beat after WAIT_MAX cycles and returns one response pulse.
// Revision : 1.0
// ============================================================================
module lsu_mem_initiator #(
    parameter int WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_good,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    output logic [1:0]  mem_maskMode,
    output logic        mem_sext,
    input  logic [31:0] mem_readData
);

    localparam int                    c_WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_load;
    logic                  r_store;
    logic                  r_sext;
    logic                  r_err;
    logic                  r_split;
    logic [1:0]            r_size;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_data;
    logic [2:0]            r_beat;
    logic [2:0]            r_nbeats;
    logic [c_WAIT_W-1:0]   r_wait;

    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_last_beat;
    logic                  w_timeout;
    logic [4:0]            w_lane;
    logic [7:0]            w_wbyte;
    logic [31:0]           w_ext;

    assign w_illegal    = (req_load == req_store) || (req_size == 2'b11);
    assign w_misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_last_beat  = ((r_beat + 3'd1) == r_nbeats);
    assign w_timeout    = (r_wait == c_WAIT_LAST);
    assign w_lane       = {r_beat[1:0], 3'b000};
    assign w_wbyte      = r_wdata[w_lane +: 8];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        mem_valid   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_illegal ? S_RESP : S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_valid = 1'b1;
                if ((mem_good && w_last_beat) || (!mem_good && w_timeout)) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load   <= 1'b0;
            r_store  <= 1'b0;
            r_sext   <= 1'b0;
            r_err    <= 1'b0;
            r_split  <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_data   <= 32'd0;
            r_beat   <= 3'd0;
            r_nbeats <= 3'd0;
            r_wait   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_load   <= req_load;
                        r_store  <= req_store;
                        r_sext   <= req_sext;
                        r_size   <= req_size;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_err    <= w_illegal;
                        r_split  <= w_misaligned;
                        r_nbeats <= w_misaligned ? ((req_size == 2'b01) ? 3'd2 : 3'd4) : 3'd1;
                        r_beat   <= 3'd0;
                        r_wait   <= '0;
                        r_data   <= 32'd0;
                    end
                end
                S_ACCESS: begin
                    if (mem_good) begin
                        // Split beats return their byte in lane 0 of readData.
                        if (r_split) begin
                            r_data[w_lane +: 8] <= mem_readData[7:0];
                        end else begin
                            r_data <= mem_readData;
                        end
                        r_beat <= r_beat + 3'd1;
                        r_wait <= '0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                        if (w_timeout) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_ext = r_data;
        case (r_size)
            2'b00:   w_ext = {{24{r_sext & r_data[7]}},  r_data[7:0]};
            2'b01:   w_ext = {{16{r_sext & r_data[15]}}, r_data[15:0]};
            default: w_ext = r_data;
        endcase
    end

    assign resp_err   = (r_state == S_RESP) && r_err;
    assign resp_rdata = ((r_state == S_RESP) && r_load && !r_err) ? w_ext : 32'd0;

    // Memory port is decoded purely from latched request state.
    assign mem_addr      = mem_valid ? (r_addr + {29'd0, r_beat}) : 32'd0;
    assign mem_writeData = mem_valid ? (r_split ? {24'd0, w_wbyte} : r_wdata) : 32'd0;
    assign mem_maskMode  = mem_valid ? (r_split ? 2'b00 : r_size) : 2'b00;
    assign mem_memRead   = mem_valid && r_load;
    assign mem_memWrite  = mem_valid && r_store;
    assign mem_sext      = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_initiator
// Brief    : Directed bench for lsu_mem_initiator with a byte-level memory
//            responder and a per-cycle expected-trace model.
// Revision : 1.0
// ============================================================================
module tb_lsu_mem_initiator;

    localparam int WAIT_MAX = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_sext;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_good;
    logic [31:0] mem_addr;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [1:0]  mem_maskMode;
    logic        mem_sext;
    logic [31:0] mem_readData;

    lsu_mem_initiator #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_load      (req_load),
        .req_store     (req_store),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_size      (req_size),
        .req_sext      (req_sext),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_valid     (mem_valid),
        .mem_good      (mem_good),
        .mem_addr      (mem_addr),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_maskMode  (mem_maskMode),
        .mem_sext      (mem_sext),
        .mem_readData  (mem_readData)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] seen_rdata;
    logic        seen_err;
    bit          stall;

    // Responder memory (written by DUT beats) and reference memory (model).
    logic [7:0]  mem     [0:255];
    logic [7:0]  ref_mem [0:255];
    bit          mem_init = 1'b0;
    logic [7:0]  ra0, ra1, ra2, ra3;

    typedef struct {
        int          kind;      // 0 idle, 1 beat, 2 response
        logic [31:0] addr;
        logic [1:0]  mask;
        logic        rd;
        logic        wr;
        logic        wfull;
        logic        wbyte;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t q[$];

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h10:    return 8'hEF;
            'h11:    return 8'hBE;
            'h12:    return 8'hAD;
            'h13:    return 8'hDE;
            'h23:    return 8'h34;
            'h24:    return 8'h92;
            default: return 8'(i * 7 + 3);
        endcase
    endfunction

    function automatic exp_t mk(input int kind);
        exp_t e;
        e.kind  = kind;
        e.addr  = 32'd0;
        e.mask  = 2'b00;
        e.rd    = 1'b0;
        e.wr    = 1'b0;
        e.wfull = 1'b0;
        e.wbyte = 1'b0;
        e.wdata = 32'd0;
        e.err   = 1'b0;
        e.rdata = 32'd0;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    assign ra0 = mem_addr[7:0];
    assign ra1 = mem_addr[7:0] + 8'd1;
    assign ra2 = mem_addr[7:0] + 8'd2;
    assign ra3 = mem_addr[7:0] + 8'd3;

    always_comb begin
        mem_good     = mem_valid && !stall;
        mem_readData = 32'd0;
        if (mem_valid && mem_memRead) begin
            case (mem_maskMode)
                2'b00:   mem_readData = {24'd0, mem[ra0]};
                2'b01:   mem_readData = {16'd0, mem[ra1], mem[ra0]};
                default: mem_readData = {mem[ra3], mem[ra2], mem[ra1], mem[ra0]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            mem_init <= 1'b1;
        end else if (mem_valid && mem_good && mem_memWrite) begin
            mem[ra0] <= mem_writeData[7:0];
            if (mem_maskMode != 2'b00) mem[ra1] <= mem_writeData[15:8];
            if (mem_maskMode == 2'b10) begin
                mem[ra2] <= mem_writeData[23:16];
                mem[ra3] <= mem_writeData[31:24];
            end
        end
    end

    // Per-cycle compare against the expected trace; empty trace means idle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) e = q.pop_front();
            else               e = mk(0);
            case (e.kind)
                1: begin
                    check("beat_mem_valid", 32'(mem_valid),    32'd1);
                    check("beat_addr",      mem_addr,          e.addr);
                    check("beat_mask",      32'(mem_maskMode), 32'(e.mask));
                    check("beat_read",      32'(mem_memRead),  32'(e.rd));
                    check("beat_write",     32'(mem_memWrite), 32'(e.wr));
                    check("beat_mem_sext",  32'(mem_sext),     32'd0);
                    check("beat_req_ready", 32'(req_ready),    32'd0);
                    check("beat_resp",      32'(resp_valid),   32'd0);
                    if (e.wfull) check("beat_wdata",  mem_writeData,            e.wdata);
                    if (e.wbyte) check("beat_wbyte",  32'(mem_writeData[7:0]),  e.wdata);
                end
                2: begin
                    check("resp_valid",     32'(resp_valid), 32'd1);
                    check("resp_err",       32'(resp_err),   32'(e.err));
                    check("resp_rdata",     resp_rdata,      e.rdata);
                    check("resp_mem_valid", 32'(mem_valid),  32'd0);
                    check("resp_req_ready", 32'(req_ready),  32'd0);
                    seen_rdata = resp_rdata;
                    seen_err   = resp_err;
                end
                default: begin
                    check("idle_req_ready", 32'(req_ready),    32'd1);
                    check("idle_mem_valid", 32'(mem_valid),    32'd0);
                    check("idle_mem_addr",  mem_addr,          32'd0);
                    check("idle_mem_rd",    32'(mem_memRead),  32'd0);
                    check("idle_mem_wr",    32'(mem_memWrite), 32'd0);
                    check("idle_resp",      32'(resp_valid),   32'd0);
                    check("idle_resp_err",  32'(resp_err),     32'd0);
                    check("idle_rdata",     resp_rdata,        32'd0);
                end
            endcase
        end
    end

    // Issue one request, build its expected cycle trace, hold req_valid (with
    // scrambled fields) while busy, and return once the DUT is idle again.
    task automatic run_req(input logic ld, input logic st, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz,
                           input logic sx, input bit stl);
        exp_t        e;
        bit          illegal;
        bit          aligned;
        int          bytes;
        int          nb;
        int          k;
        logic [31:0] v;
        req_valid = 1'b1;
        req_load  = ld;
        req_store = st;
        req_addr  = a;
        req_wdata = wd;
        req_size  = sz;
        req_sext  = sx;
        stall     = stl;
        illegal   = (ld == st) || (sz == 2'b11);
        if (illegal) begin
            e = mk(2);
            e.err = 1'b1;
            q.push_back(e);
        end else begin
            bytes   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            aligned = ((a & 32'(bytes - 1)) == 32'd0);
            nb      = aligned ? 1 : bytes;
            for (int i = 0; i < (stl ? WAIT_MAX : nb); i++) begin
                e       = mk(1);
                e.addr  = aligned ? a : a + 32'(stl ? 0 : i);
                e.mask  = aligned ? sz : 2'b00;
                e.rd    = ld;
                e.wr    = st;
                e.wfull = st && aligned;
                e.wbyte = st && !aligned;
                e.wdata = aligned ? wd : {24'd0, wd[8*(stl ? 0 : i) +: 8]};
                q.push_back(e);
            end
            e = mk(2);
            if (stl) begin
                e.err = 1'b1;
            end else begin
                if (st) begin
                    for (int b = 0; b < bytes; b++) ref_mem[8'(a + 32'(b))] = wd[8*b +: 8];
                end
                v = 32'd0;
                for (int b = 0; b < bytes; b++) v[8*b +: 8] = ref_mem[8'(a + 32'(b))];
                if (bytes == 1)      v = {{24{sx & v[7]}},  v[7:0]};
                else if (bytes == 2) v = {{16{sx & v[15]}}, v[15:0]};
                e.rdata = ld ? v : 32'd0;
            end
            q.push_back(e);
        end
        q.push_back(mk(0));
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (q.size() != 0) begin
                req_addr  = $urandom;
                req_wdata = $urandom;
                req_sext  = ~req_sext;
            end
        end while (q.size() != 0 && k < 200);
        if (q.size() != 0) begin
            check("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        req_valid = 1'b0;
        stall     = 1'b0;
    endtask

    task automatic reset_mid_store();
        exp_t        e;
        int          k;
        logic [31:0] wd;
        wd        = 32'hA1B2C3D4;
        req_valid = 1'b1;
        req_load  = 1'b0;
        req_store = 1'b1;
        req_addr  = 32'h41;
        req_wdata = wd;
        req_size  = 2'b10;
        req_sext  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e       = mk(1);
            e.addr  = 32'h41 + 32'(i);
            e.wr    = 1'b1;
            e.wbyte = 1'b1;
            e.wdata = {24'd0, wd[8*i +: 8]};
            q.push_back(e);
        end
        // Only the first two byte beats complete before reset hits.
        ref_mem[8'h41] = wd[7:0];
        ref_mem[8'h42] = wd[15:8];
        @(posedge clk);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (q.size() != 0 && k < 50);
        if (q.size() != 0) begin
            check("rst_drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
        end
        req_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("rst_mid_mem_valid", 32'(mem_valid),    32'd0);
        check("rst_mid_mem_write", 32'(mem_memWrite), 32'd0);
        check("rst_mid_resp",      32'(resp_valid),   32'd0);
        check("rst_mid_req_ready", 32'(req_ready),    32'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        reset     = 1'b0;
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_size  = 2'b00;
        req_sext  = 1'b0;
        stall     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'd1);
        check("rst_mem_valid",  32'(mem_valid),  32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        run_req(1'b1, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0);
        check("t1_word_load", seen_rdata, 32'hDEADBEEF);
        check("t1_err",       32'(seen_err), 32'd0);

        run_req(1'b0, 1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, 1'b0);
        check("sb_rdata_zero", seen_rdata, 32'd0);
        run_req(1'b1, 1'b0, 32'h13, 32'd0, 2'b00, 1'b1, 1'b0);
        check("t2_byte_sext", seen_rdata, 32'hFFFFFF80);
        run_req(1'b1, 1'b0, 32'h13, 32'd0, 2'b00, 1'b0, 1'b0);
        check("t2_byte_zext", seen_rdata, 32'h00000080);

        run_req(1'b1, 1'b0, 32'h23, 32'd0, 2'b01, 1'b1, 1'b0);
        check("t4_mis_half_sext", seen_rdata, 32'hFFFF9234);

        run_req(1'b0, 1'b1, 32'h21, 32'h11223344, 2'b10, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 1'b0);
        check("t3_word20_hi", 32'(seen_rdata[31:8]), 32'h00223344);
        run_req(1'b1, 1'b0, 32'h24, 32'd0, 2'b10, 1'b0, 1'b0);
        check("t3_word24_lo", 32'(seen_rdata[7:0]), 32'h00000011);

        run_req(1'b0, 1'b1, 32'hFFFFFFFF, 32'h0000A55A, 2'b01, 1'b0, 1'b0);
        run_req(1'b1, 1'b0, 32'hFFFFFFFF, 32'd0, 2'b01, 1'b1, 1'b0);
        check("wrap_half_sext", seen_rdata, 32'hFFFFA55A);

        run_req(1'b1, 1'b0, 32'h30, 32'd0, 2'b10, 1'b0, 1'b1);
        check("t5_timeout_err",   32'(seen_err), 32'd1);
        check("t5_timeout_rdata", seen_rdata,    32'd0);
        run_req(1'b1, 1'b0, 32'h10, 32'd0, 2'b00, 1'b0, 1'b0);
        check("t5_after_timeout", seen_rdata, 32'h000000EF);

        run_req(1'b1, 1'b1, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0);
        check("t6_ld_st_err", 32'(seen_err), 32'd1);
        run_req(1'b1, 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 1'b0);
        check("t6_size3_err", 32'(seen_err), 32'd1);
        run_req(1'b0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 1'b0);
        check("t6_none_err",  32'(seen_err), 32'd1);

        reset_mid_store();
        run_req(1'b1, 1'b0, 32'h40, 32'd0, 2'b10, 1'b0, 1'b0);
        check("rst_committed_bytes", 32'(seen_rdata[23:8]), 32'h0000C3D4);
        run_req(1'b1, 1'b0, 32'h44, 32'd0, 2'b00, 1'b0, 1'b0);
        check("rst_untouched_byte", seen_rdata, 32'h000000DF);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
